// File: rtl/keystream_serializer.sv
`timescale 1ns/1ps
// ============================================================================
// keystream_serializer
// ----------------------------------------------------------------------------
// Bridges a ChaCha20 block core to a byte-wide valid/ready consumer.
// A small request FSM asks the core for 512-bit keystream blocks with an
// incrementing block index. Each captured block is then streamed out as 64
// bytes, least-significant byte first. Two block buffers are used: the output
// shift register currently draining, and a pending buffer holding the next
// block. The next block can therefore be computed while the current one
// drains, and the byte stream has no bubble at block boundaries.
//
// Parameters
//   INDEX_WIDTH : width of the internal block counter (1..64)
//   INDEX_INIT  : counter value after reset
//
// Ports
//   i_clock          : clock
//   i_reset          : asynchronous, active-high reset
//   i_enable         : permits new block requests
//   o_chacha_start   : one-cycle request pulse to the core
//   o_chacha_index   : block index (counter zero-extended to 64 bits)
//   i_chacha_done    : core done level
//   i_chacha_out     : 512-bit keystream block from the core
//   o_byte_data      : current output byte
//   o_byte_valid     : o_byte_data is valid
//   i_byte_ready     : consumer accepts the byte
//   o_exhausted      : sticky, set once the all-ones index has been used
//   o_busy           : request in flight or any buffered block present
// ============================================================================
module keystream_serializer #(
    parameter int                     INDEX_WIDTH = 64,
    parameter logic [INDEX_WIDTH-1:0] INDEX_INIT  = '0
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_enable,
    output logic         o_chacha_start,
    output logic [63:0]  o_chacha_index,
    input  logic         i_chacha_done,
    input  logic [511:0] i_chacha_out,
    output logic [7:0]   o_byte_data,
    output logic         o_byte_valid,
    input  logic         i_byte_ready,
    output logic         o_exhausted,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_START = 2'd1,
        C_ARM   = 2'd2,
        C_WAIT  = 2'd3
    } state_t;

    // Request FSM and block counter
    state_t                 r_state;
    logic                   r_start;
    logic [INDEX_WIDTH-1:0] r_counter;
    logic                   r_exhausted;

    // Output stage and pending buffer
    logic [511:0]           r_shift;
    logic [5:0]             r_byte_cnt;
    logic                   r_out_valid;
    logic [511:0]           r_pend;
    logic                   r_pend_full;

    // Combinational helpers
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_out_free;
    logic                   w_capture;
    logic                   w_counter_max;
    logic [63:0]            w_index;

    // Handshake and capture decode
    always_comb begin
        w_xfer        = r_out_valid && i_byte_ready;
        w_last_xfer   = w_xfer && (r_byte_cnt == 6'd63);
        // Output stage is free on this edge if empty or its last byte leaves now
        w_out_free    = (!r_out_valid) || w_last_xfer;
        w_capture     = (r_state == C_WAIT) && i_chacha_done;
        w_counter_max = (r_counter == {INDEX_WIDTH{1'b1}});
    end

    // Zero-extend the block counter onto the 64-bit index bus
    always_comb begin
        w_index                  = 64'd0;
        w_index[INDEX_WIDTH-1:0] = r_counter;
    end

    // Request FSM: start pulse, index counter and exhaustion flag
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= C_IDLE;
            r_start     <= 1'b0;
            r_counter   <= INDEX_INIT;
            r_exhausted <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    // Only request when there is somewhere to put the result
                    if (i_enable && !r_pend_full && !r_exhausted) begin
                        r_state <= C_START;
                        r_start <= 1'b1;
                    end
                end
                C_START: begin
                    r_state <= C_ARM;
                end
                C_ARM: begin
                    // Core still shows the previous done level this cycle
                    r_state <= C_WAIT;
                end
                C_WAIT: begin
                    if (i_chacha_done) begin
                        r_state <= C_IDLE;
                        // The all-ones index is the last one; hold it there
                        if (w_counter_max) begin
                            r_exhausted <= 1'b1;
                        end else begin
                            r_counter <= r_counter + INDEX_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    // Output shift register, byte counter and pending buffer
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift     <= 512'd0;
            r_byte_cnt  <= 6'd0;
            r_out_valid <= 1'b0;
            r_pend      <= 512'd0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_capture && w_out_free) begin
                // Fresh block goes straight to the output stage
                r_shift     <= i_chacha_out;
                r_byte_cnt  <= 6'd0;
                r_out_valid <= 1'b1;
            end else if (w_last_xfer) begin
                if (r_pend_full) begin
                    // Seamless hand-over from the pending buffer
                    r_shift     <= r_pend;
                    r_byte_cnt  <= 6'd0;
                    r_out_valid <= 1'b1;
                    r_pend_full <= 1'b0;
                end else begin
                    r_shift     <= {8'h00, r_shift[511:8]};
                    r_byte_cnt  <= 6'd0;
                    r_out_valid <= 1'b0;
                end
            end else if (w_xfer) begin
                r_shift    <= {8'h00, r_shift[511:8]};
                r_byte_cnt <= r_byte_cnt + 6'd1;
            end

            // Output stage still busy: park the new block
            if (w_capture && !w_out_free) begin
                r_pend      <= i_chacha_out;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign o_chacha_start = r_start;
    assign o_chacha_index = w_index;
    assign o_byte_data    = r_shift[7:0];
    assign o_byte_valid   = r_out_valid;
    assign o_exhausted    = r_exhausted;
    assign o_busy         = (r_state != C_IDLE) || r_out_valid || r_pend_full;

endmodule

// File: doc/keystream_serializer.md
# keystream_serializer

Sits between the `chacha20` core and `uart_tx_8n1`. It requests 512-bit keystream blocks with an incrementing block index, captures each `out` word, and streams it as 64 bytes over a valid/ready byte interface. The block is double-buffered: the next ChaCha block is computed while the current one drains, so the byte stream has no bubble at block boundaries. The UART-side pacing FSM in the top level consumes the byte stream.

## Interface
- `INDEX_WIDTH`, 64: width of the internal block counter. Value range 1..64. `chacha_index` is this counter zero-extended to 64 bits.
- `INDEX_INIT`, 0: counter value after reset.
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: permits new block requests.
- `chacha_start` out 1: one-cycle request pulse to `chacha20.start`.
- `chacha_index` out 64: block index presented to `chacha20.index`.
- `chacha_done` in 1: level from `chacha20.done`. The core clears it the cycle after it samples `start`.
- `chacha_out` in 512: keystream block.
- `byte_data` out 8: current byte.
- `byte_valid` out 1: `byte_data` is valid.
- `byte_ready` in 1: consumer accepts a byte.
- `exhausted` out 1: sticky flag. Set when the counter has reached all-ones.
- `busy` out 1: high when the request FSM is not in `C_IDLE`, or either buffer is full.

## Operation
- Reset values (asynchronous):
  - `chacha_start`=0, `byte_valid`=0, `byte_data`=0, `exhausted`=0, `busy`=0.
  - counter=`INDEX_INIT`.
  - Both buffers empty; FSM in `C_IDLE`.
- Request FSM states and transitions:
  - `C_IDLE`: go to `C_START` when `enable` && pending buffer empty && !`exhausted`.
  - `C_START`: `chacha_start`=1 for this cycle. Go to `C_ARM`.
  - `C_ARM`: `chacha_done` is ignored. Go to `C_WAIT`.
  - `C_WAIT`: on `chacha_done`=1, capture `chacha_out`, then return to `C_IDLE`. Capture target:
    - If the output stage will be empty on this edge (empty, or last byte accepted this cycle), load the output shift register directly.
    - Otherwise load the pending buffer.
- On capture:
  - If the counter equals all-ones (`INDEX_WIDTH` bits), set `exhausted` and hold the counter.
  - Otherwise increment the counter by 1.
- Output stage:
  - 512-bit shift register plus a 6-bit byte counter.
  - `byte_data` = shift[7:0]. Byte k of a block = `chacha_out[8k+7:8k]`, so bytes go out LSB first.
  - A transfer occurs when `byte_valid && byte_ready`. On a transfer: shift right by 8, counter +1.
  - After byte 63 transfers:
    - Load the pending buffer in the same edge if it is full (`byte_valid` stays 1), and mark pending empty.
    - Otherwise `byte_valid`=0.
- `enable` low:
  - No new `C_START`.
  - An in-flight request (`C_START`/`C_ARM`/`C_WAIT`) completes and is captured.
  - Buffered bytes keep draining.
- `exhausted`:
  - No further requests.
  - Remaining buffered bytes drain.
  - Cleared only by reset.
- Simultaneous last-byte-accept and capture in `C_WAIT`: the captured block goes to the output register. The pending buffer stays empty.

## Timing
- `enable` sampled high at edge k in `C_IDLE` → `chacha_start`=1 during cycle k+1 only, `C_ARM` during k+2, `C_WAIT` from k+3.
- `chacha_index` is stable from `C_START` until capture. It changes on the capture edge.
- `chacha_done` sampled at edge d with output stage empty → `byte_valid`=1 and byte 0 on `byte_data` from d+1.
- While `byte_valid` && !`byte_ready`, `byte_data` holds.
- Sustained `byte_ready`=1 gives 1 byte/cycle, including across block boundaries, provided the next block is captured before byte 63 is accepted.
- Reset mid-operation discards any in-flight request. A `chacha_done` arriving after reset release is ignored, because the FSM is in `C_IDLE`.

## Test plan
1. Reset, `enable`=1, `byte_ready`=1, chacha model with 4-cycle latency and `out` byte k = k ^ (index·0x11) → bytes 0x00..0x3F for index 0, then block 1 bytes. Exactly one `chacha_start` per block; `chacha_index` reads 0, 1, 2.
2. Random `byte_ready` (50%) → byte sequence identical to scenario 1. `byte_data` never changes while valid && !ready.
3. `byte_ready`=1, model latency 10 → after the first byte, `byte_valid` stays 1 continuously for ≥3 blocks (192 bytes with no gap).
4. `INDEX_WIDTH`=2, `enable`=1 → exactly 4 `chacha_start` pulses, 256 bytes out, `exhausted`=1 after the 4th capture, `chacha_index` holds 3, no further starts.
5. `enable` dropped while in `C_ARM` → that block is captured and all its bytes drain; no further start. Re-enable → next start uses the incremented index.
6. `reset` asserted in `C_WAIT` with bytes buffered → `byte_valid`, `chacha_start`, `busy` drop asynchronously and `chacha_index`=0. A late `chacha_done` after release produces no bytes.
